// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : ID-stage producer-side hazard tracker for a dual-issue pipe.
//               Tracks destinations whose results the EX forwarding network
//               cannot yet reach (loads, multiplies and divides), and stalls
//               or splits the ID pair until every source is forwardable.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               ID_*_a / ID_*_b       - decoded slot A / slot B fields
//               EX_flush              - mispredict flush of ID/EX
//               MEM_div_done/_waddr   - divider writeback
//               ID_stall              - issue neither slot
//               ID_split              - issue slot A only
//               SB_pending            - registered per-register pending map
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
  parameter int LAT_W = 3,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid_a,
  input  logic             ID_valid_b,
  input  logic [4:0]       ID_rf_raddr_a1,
  input  logic [4:0]       ID_rf_raddr_a2,
  input  logic [4:0]       ID_rf_raddr_b1,
  input  logic [4:0]       ID_rf_raddr_b2,
  input  logic [4:0]       ID_rf_waddr_a,
  input  logic [4:0]       ID_rf_waddr_b,
  input  logic             ID_rf_we_a,
  input  logic             ID_rf_we_b,
  input  logic [LAT_W-1:0] ID_lat_a,
  input  logic [LAT_W-1:0] ID_lat_b,
  input  logic             ID_long_a,
  input  logic             ID_long_b,
  input  logic             EX_flush,
  input  logic             MEM_div_done,
  input  logic [4:0]       MEM_div_waddr,
  output logic             ID_stall,
  output logic             ID_split,
  output logic [NREG-1:0]  SB_pending
);

  logic [NREG-1:0][LAT_W-1:0] r_cnt;
  logic [NREG-1:0][LAT_W-1:0] w_cnt_nxt;
  logic [NREG-1:0]            r_busy;
  logic [NREG-1:0]            w_busy_nxt;
  logic [NREG-1:0]            w_pend;
  logic [NREG-1:0]            w_pend_nxt;

  logic w_stall_a, w_stall_b, w_intra, w_stall_raw;
  logic w_issue_a, w_issue_b, w_wr_a, w_wr_b;

  // Current-state pending map; r0 is never pending.
  always_comb begin
    w_pend = '0;
    for (int i = 1; i < NREG; i++) begin
      w_pend[i] = (r_cnt[i] != '0) || r_busy[i];
    end
  end

  // A destination that is still busy on the divider is a WAW hazard: the
  // divide would otherwise retire after the younger write.
  assign w_stall_a = ID_valid_a && (w_pend[ID_rf_raddr_a1] || w_pend[ID_rf_raddr_a2] ||
                                    (ID_rf_we_a && r_busy[ID_rf_waddr_a]));
  assign w_stall_b = ID_valid_b && (w_pend[ID_rf_raddr_b1] || w_pend[ID_rf_raddr_b2] ||
                                    (ID_rf_we_b && r_busy[ID_rf_waddr_b]));

  // Slot B depends on slot A within the same pair. State cannot see this yet,
  // so B is pushed to the next cycle. Two writes to the same register where A
  // is a divide must also be split so the divide's busy bit is not lost.
  assign w_intra = ID_valid_a && ID_valid_b && ID_rf_we_a && (ID_rf_waddr_a != 5'd0) &&
                   ((ID_rf_raddr_b1 == ID_rf_waddr_a) || (ID_rf_raddr_b2 == ID_rf_waddr_a) ||
                    (ID_long_a && ID_rf_we_b && (ID_rf_waddr_b == ID_rf_waddr_a)));

  assign w_stall_raw = w_stall_a || (!ID_valid_a && w_stall_b);
  assign ID_stall    = !EX_flush && w_stall_raw;
  assign ID_split    = !EX_flush && !w_stall_raw && ID_valid_b && (w_stall_b || w_intra);

  assign w_issue_a = ID_valid_a && !ID_stall && !EX_flush;
  assign w_issue_b = ID_valid_b && !ID_stall && !ID_split && !EX_flush;
  assign w_wr_a    = w_issue_a && ID_rf_we_a && (ID_rf_waddr_a != 5'd0);
  assign w_wr_b    = w_issue_b && ID_rf_we_b && (ID_rf_waddr_b != 5'd0);

  // Next state, later statements take priority over earlier ones.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = (r_cnt[i] != '0) ? (r_cnt[i] - LAT_W'(1)) : '0;
    end
    w_busy_nxt = r_busy;
    if (MEM_div_done) begin
      w_busy_nxt[MEM_div_waddr] = 1'b0;
    end
    // The divider op is older than the mispredicted branch, so busy survives.
    if (EX_flush) begin
      w_cnt_nxt = '0;
    end
    if (w_wr_a) begin
      w_cnt_nxt[ID_rf_waddr_a]  = ID_long_a ? '0 : ID_lat_a;
      w_busy_nxt[ID_rf_waddr_a] = ID_long_a;
    end
    // Slot B is younger, so it overrides A on an equal destination.
    if (w_wr_b) begin
      w_cnt_nxt[ID_rf_waddr_b]  = ID_long_b ? '0 : ID_lat_b;
      w_busy_nxt[ID_rf_waddr_b] = ID_long_b;
    end
    w_cnt_nxt[0]  = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      w_pend_nxt[i] = (w_cnt_nxt[i] != '0) || w_busy_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_busy     <= '0;
      SB_pending <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      SB_pending <= w_pend_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard. A model
//               keeps, per register, the absolute cycle at which its result
//               becomes forwardable plus a divider-busy flag, and is compared
//               against the DUT every cycle; directed steps also carry
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

  localparam int LAT_W = 3;
  localparam int NREG  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ID_valid_a, ID_valid_b;
  logic [4:0]       ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2;
  logic [4:0]       ID_rf_waddr_a, ID_rf_waddr_b;
  logic             ID_rf_we_a, ID_rf_we_b;
  logic [LAT_W-1:0] ID_lat_a, ID_lat_b;
  logic             ID_long_a, ID_long_b;
  logic             EX_flush;
  logic             MEM_div_done;
  logic [4:0]       MEM_div_waddr;
  logic             ID_stall, ID_split;
  logic [NREG-1:0]  SB_pending;

  issue_scoreboard #(.LAT_W(LAT_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .ID_valid_a(ID_valid_a), .ID_valid_b(ID_valid_b),
    .ID_rf_raddr_a1(ID_rf_raddr_a1), .ID_rf_raddr_a2(ID_rf_raddr_a2),
    .ID_rf_raddr_b1(ID_rf_raddr_b1), .ID_rf_raddr_b2(ID_rf_raddr_b2),
    .ID_rf_waddr_a(ID_rf_waddr_a), .ID_rf_waddr_b(ID_rf_waddr_b),
    .ID_rf_we_a(ID_rf_we_a), .ID_rf_we_b(ID_rf_we_b),
    .ID_lat_a(ID_lat_a), .ID_lat_b(ID_lat_b),
    .ID_long_a(ID_long_a), .ID_long_b(ID_long_b),
    .EX_flush(EX_flush), .MEM_div_done(MEM_div_done), .MEM_div_waddr(MEM_div_waddr),
    .ID_stall(ID_stall), .ID_split(ID_split), .SB_pending(SB_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: ready[r] = first cycle in which r's result is forwardable.
  int cyc = 0;
  int ready[NREG];
  bit busy_m[NREG];
  bit chk = 1'b0;

  function automatic bit mpend(input logic [4:0] r);
    return (r != 5'd0) && ((cyc < ready[r]) || busy_m[r]);
  endfunction

  function automatic void model_out(output bit st, output bit sp);
    bit sa, sb, intra;
    sa = ID_valid_a && (mpend(ID_rf_raddr_a1) || mpend(ID_rf_raddr_a2) ||
                        (ID_rf_we_a && busy_m[ID_rf_waddr_a]));
    sb = ID_valid_b && (mpend(ID_rf_raddr_b1) || mpend(ID_rf_raddr_b2) ||
                        (ID_rf_we_b && busy_m[ID_rf_waddr_b]));
    intra = ID_valid_a && ID_valid_b && ID_rf_we_a && (ID_rf_waddr_a != 0) &&
            ((ID_rf_raddr_b1 == ID_rf_waddr_a) || (ID_rf_raddr_b2 == ID_rf_waddr_a) ||
             (ID_long_a && ID_rf_we_b && (ID_rf_waddr_b == ID_rf_waddr_a)));
    st = sa || (!ID_valid_a && sb);
    sp = !st && ID_valid_b && (sb || intra);
    if (EX_flush) begin
      st = 1'b0;
      sp = 1'b0;
    end
  endfunction

  // Issue at cycle cyc with latency L: forwardable from cycle cyc+L+1.
  function automatic void apply(input logic [4:0] r, input logic lng, input logic [LAT_W-1:0] lat);
    if (lng) begin
      busy_m[r] = 1'b1;
      ready[r]  = 0;
    end else begin
      busy_m[r] = 1'b0;
      ready[r]  = cyc + int'(lat) + 1;
    end
  endfunction

  always @(posedge clk) begin
    bit st, sp;
    model_out(st, sp);
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        ready[r]  = 0;
        busy_m[r] = 1'b0;
      end
    end else begin
      if (MEM_div_done) busy_m[MEM_div_waddr] = 1'b0;
      if (EX_flush) begin
        for (int r = 0; r < NREG; r++) begin
          if (ready[r] > cyc + 1) ready[r] = cyc + 1;
        end
      end
      if (ID_valid_a && !st && !EX_flush && ID_rf_we_a && ID_rf_waddr_a != 0)
        apply(ID_rf_waddr_a, ID_long_a, ID_lat_a);
      if (ID_valid_b && !st && !sp && !EX_flush && ID_rf_we_b && ID_rf_waddr_b != 0)
        apply(ID_rf_waddr_b, ID_long_b, ID_lat_b);
    end
    cyc = cyc + 1;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit st, sp;
    logic [NREG-1:0] pv;
    if (chk) begin
      model_out(st, sp);
      for (int r = 0; r < NREG; r++) pv[r] = mpend(5'(r));
      total = total + 1;
      if (ID_stall !== st) begin
        bad = bad + 1;
        $display("FAIL model_stall cyc=%0d: got %b want %b", cyc, ID_stall, st);
      end
      total = total + 1;
      if (ID_split !== sp) begin
        bad = bad + 1;
        $display("FAIL model_split cyc=%0d: got %b want %b", cyc, ID_split, sp);
      end
      total = total + 1;
      if (SB_pending !== pv) begin
        bad = bad + 1;
        $display("FAIL model_pending cyc=%0d: got %h want %h", cyc, SB_pending, pv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input int r1, input int r2, input int wa,
                       input bit we, input int lat, input bit lng);
    ID_valid_a = v; ID_rf_raddr_a1 = 5'(r1); ID_rf_raddr_a2 = 5'(r2);
    ID_rf_waddr_a = 5'(wa); ID_rf_we_a = we; ID_lat_a = LAT_W'(lat); ID_long_a = lng;
  endtask

  task automatic set_b(input bit v, input int r1, input int r2, input int wa,
                       input bit we, input int lat, input bit lng);
    ID_valid_b = v; ID_rf_raddr_b1 = 5'(r1); ID_rf_raddr_b2 = 5'(r2);
    ID_rf_waddr_b = 5'(wa); ID_rf_we_b = we; ID_lat_b = LAT_W'(lat); ID_long_b = lng;
  endtask

  task automatic idle();
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
    EX_flush = 1'b0; MEM_div_done = 1'b0; MEM_div_waddr = 5'd0;
  endtask

  // Waits for the mid-cycle point and checks the hand-computed outputs.
  task automatic expect_out(input bit s, input bit sp, input string nm);
    @(negedge clk);
    total = total + 1;
    if (ID_stall !== s || ID_split !== sp) begin
      bad = bad + 1;
      $display("FAIL %s: stall,split got %b,%b want %b,%b", nm, ID_stall, ID_split, s, sp);
    end
  endtask

  task automatic check_pend(input int idx, input bit v, input string nm);
    total = total + 1;
    if (SB_pending[idx] !== v) begin
      bad = bad + 1;
      $display("FAIL %s: SB_pending[%0d] got %b want %b", nm, idx, SB_pending[idx], v);
    end
  endtask

  task automatic check_pend_all_zero(input string nm);
    total = total + 1;
    if (SB_pending !== '0) begin
      bad = bad + 1;
      $display("FAIL %s: SB_pending got %h want 0", nm, SB_pending);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk = 1'b1;

    // Reset state
    expect_out(0, 0, "reset_outputs");
    check_pend_all_zero("reset_pending");
    tick();

    // Load-use: lw r5 lat=2, then add r6 = r5
    set_a(1, 0, 0, 5, 1, 2, 0);
    expect_out(0, 0, "lw_issue"); tick();
    set_a(1, 5, 0, 6, 1, 0, 0);
    expect_out(1, 0, "lu_stall1"); check_pend(5, 1, "lu_pend1"); tick();
    expect_out(1, 0, "lu_stall2"); tick();
    expect_out(0, 0, "lu_issue"); check_pend(5, 0, "lu_pend0"); tick();
    idle();

    // Intra-pair: A add r3, B reads r3 -> split, then B issues alone
    set_a(1, 1, 0, 3, 1, 0, 0);
    set_b(1, 3, 0, 8, 1, 0, 0);
    expect_out(0, 1, "intra_split"); tick();
    set_a(1, 3, 0, 8, 1, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
    expect_out(0, 0, "intra_next"); tick();
    idle();

    // Divide r7
    set_a(1, 1, 2, 7, 1, 0, 1);
    expect_out(0, 0, "div_issue"); tick();
    set_a(1, 7, 0, 9, 1, 0, 0);
    expect_out(1, 0, "div_rd_stall"); check_pend(7, 1, "div_pend"); tick();
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(1, 7, 0, 12, 1, 0, 0);
    expect_out(1, 0, "div_b_only_stall"); tick();
    set_a(1, 1, 0, 11, 1, 0, 0);
    expect_out(0, 1, "div_b_split"); tick();
    set_b(0, 0, 0, 0, 0, 0, 0);
    set_a(1, 1, 0, 7, 1, 0, 0);
    expect_out(1, 0, "div_waw_stall"); tick();
    set_a(1, 7, 0, 9, 1, 0, 0);
    MEM_div_done = 1'b1; MEM_div_waddr = 5'd7;
    expect_out(1, 0, "div_done_same"); tick();
    MEM_div_done = 1'b0; MEM_div_waddr = 5'd0;
    expect_out(0, 0, "div_after_done"); check_pend(7, 0, "div_pend0"); tick();
    idle();

    // Flush: lw r9 lat=3 with div r4, then flush
    set_a(1, 0, 0, 9, 1, 3, 0);
    set_b(1, 0, 0, 4, 1, 0, 1);
    expect_out(0, 0, "fl_issue"); tick();
    set_b(0, 0, 0, 0, 0, 0, 0);
    set_a(1, 9, 0, 10, 1, 0, 0);
    EX_flush = 1'b1;
    expect_out(0, 0, "fl_forced"); check_pend(9, 1, "fl_pend9"); check_pend(4, 1, "fl_pend4"); tick();
    EX_flush = 1'b0;
    expect_out(0, 0, "fl_rd9"); check_pend(9, 0, "fl_pend9_0"); check_pend(4, 1, "fl_pend4_kept"); tick();
    set_a(1, 4, 0, 10, 1, 0, 0);
    expect_out(1, 0, "fl_rd4_stall"); tick();
    idle();
    MEM_div_done = 1'b1; MEM_div_waddr = 5'd4;
    tick();
    idle();

    // WAW in pair: A lat=3 r2, B lat=0 r2
    set_a(1, 0, 0, 2, 1, 3, 0);
    set_b(1, 0, 0, 2, 1, 0, 0);
    expect_out(0, 0, "waw_issue"); tick();
    set_b(0, 0, 0, 0, 0, 0, 0);
    set_a(1, 2, 0, 13, 1, 0, 0);
    expect_out(0, 0, "waw_rd"); check_pend(2, 0, "waw_pend"); tick();
    idle();

    // Reset mid-operation: div r7 and lw r5 lat=2, then reset
    set_a(1, 0, 0, 7, 1, 0, 1);
    set_b(1, 0, 0, 5, 1, 2, 0);
    expect_out(0, 0, "rm_issue"); tick();
    idle();
    rst = 1'b1;
    expect_out(0, 0, "rm_in_reset"); check_pend(7, 1, "rm_pend7"); tick();
    rst = 1'b0;
    set_a(1, 5, 0, 14, 1, 0, 0);
    set_b(1, 7, 0, 15, 1, 0, 0);
    expect_out(0, 0, "rm_readers"); check_pend_all_zero("rm_pending"); tick();
    set_a(1, 0, 0, 0, 0, 0, 0);
    set_b(1, 0, 0, 0, 0, 0, 0);
    expect_out(0, 0, "r0_reads"); tick();
    idle();
    tick();

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
